mont_exp_engine: RTL and testbench

Montgomery-domain modular exponentiation engine: computes M^e mod n with left-to-right binary square-and-multiply over a bit-serial Montgomery multiplier. The block pairs the `mon_exp` controller with its `bram` operand memory. The host preloads Montgomery-form operands through a dedicated write port, pulses `start`, and reads `ans` when `stop` rises. It sits under the RSA top level as the exponentiation core.

---
 rtl/mont_exp_engine_pkg.sv | 35 +++
 rtl/mont_exp_engine_bram.sv | 37 +++
 rtl/mont_exp_engine_mont_mul.sv | 107 ++++++++++
 rtl/mont_exp_engine.sv | 211 +++++++++++++++++++++
 tb/tb_mont_exp_engine.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/mont_exp_engine_pkg.sv
// Shared definitions for the Montgomery exponentiation engine: default
// widths, operand memory map and the state encodings used by the
// exponentiation controller and the bit-serial Montgomery multiplier.
package mont_exp_engine_pkg;

    localparam int BIT_LEN_DEFAULT = 512;
    localparam int DBITS_DEFAULT   = 512;
    localparam int ABITS_DEFAULT   = 8;

    // Operand memory map, one word per address. Only low words are used.
    localparam logic [ABITS_DEFAULT-1:0] ADDR_X_LO = 8'd0;
    localparam logic [ABITS_DEFAULT-1:0] ADDR_X_HI = 8'd1;
    localparam logic [ABITS_DEFAULT-1:0] ADDR_M_LO = 8'd2;
    localparam logic [ABITS_DEFAULT-1:0] ADDR_M_HI = 8'd3;

    // Exponentiation controller states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_X,
        ST_RD_M,
        ST_SQR,
        ST_MUL,
        ST_CONV,
        ST_WB,
        ST_DONE
    } exp_state_e;

    // Montgomery multiplier states
    typedef enum logic [1:0] {
        MM_IDLE,
        MM_ITER,
        MM_SUB
    } mm_state_e;

endpackage

// File: rtl/mont_exp_engine_bram.sv
// Operand memory: two write ports and one synchronous read port.
// Ports:
//   clk                      rising-edge clock
//   wr_a_en/addr/data        engine write port (wins on address collision)
//   wr_b_en/addr/data        host write port
//   rd_addr / rd_data        read port, one cycle latency
// Contents are deliberately not reset.
module bram #(
    parameter int ABITS = 8,
    parameter int DBITS = 512
) (
    input  logic             clk,
    input  logic             wr_a_en,
    input  logic [ABITS-1:0] wr_a_addr,
    input  logic [DBITS-1:0] wr_a_data,
    input  logic             wr_b_en,
    input  logic [ABITS-1:0] wr_b_addr,
    input  logic [DBITS-1:0] wr_b_data,
    input  logic [ABITS-1:0] rd_addr,
    output logic [DBITS-1:0] rd_data
);

    logic [DBITS-1:0] mem [2**ABITS];

    // Port A is written after port B so that it wins a same-address,
    // same-cycle collision.
    always_ff @(posedge clk) begin
        if (wr_b_en) begin
            mem[wr_b_addr] <= wr_b_data;
        end
        if (wr_a_en) begin
            mem[wr_a_addr] <= wr_a_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/mont_exp_engine_mont_mul.sv
// Bit-serial Montgomery product MonPro(a, b) = a*b*2^-k mod n.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          one-cycle request; operands latched while idle
//   a, b, n        operands and odd modulus (a, b < n expected)
//   k              iteration count (bit length of n); 0 gives result 0
//   done           one-cycle pulse when result is valid
//   result         reduced product, held until the next request completes
module mont_mul
    import mont_exp_engine_pkg::*;
#(
    parameter int W = BIT_LEN_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] n,
    input  logic [9:0]   k,
    output logic         done,
    output logic [W-1:0] result
);

    mm_state_e    state, state_nx;
    logic [W-1:0] a_sh;
    logic [W-1:0] b_reg;
    logic [W-1:0] n_reg;
    logic [W+1:0] t;
    logic [9:0]   j;
    logic [9:0]   k_reg;
    logic [W+1:0] sum;
    logic [W+1:0] sum_odd;
    logic [W+1:0] t_red;

    // Two extra bits keep t < 4n, so the add-then-halve never overflows.
    assign sum     = t + (a_sh[0] ? {2'b00, b_reg} : '0);
    assign sum_odd = sum[0] ? (sum + {2'b00, n_reg}) : sum;
    assign t_red   = (t >= {2'b00, n_reg}) ? (t - {2'b00, n_reg}) : t;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MM_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: k iteration cycles, then a single final-subtract cycle
    always_comb begin
        state_nx = state;
        case (state)
            MM_IDLE: begin
                if (start) begin
                    state_nx = (k == 10'd0) ? MM_SUB : MM_ITER;
                end
            end
            MM_ITER: begin
                if (j == k_reg - 10'd1) begin
                    state_nx = MM_SUB;
                end
            end
            MM_SUB:  state_nx = MM_IDLE;
            default: state_nx = MM_IDLE;
        endcase
    end

    // Datapath: a is shifted right so its next bit is always at a_sh[0]
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_reg  <= '0;
            n_reg  <= '0;
            k_reg  <= '0;
            t      <= '0;
            j      <= '0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                MM_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_reg <= b;
                        n_reg <= n;
                        k_reg <= k;
                        t     <= '0;
                        j     <= '0;
                    end
                end
                MM_ITER: begin
                    t    <= sum_odd >> 1;
                    a_sh <= a_sh >> 1;
                    j    <= j + 10'd1;
                end
                MM_SUB: begin
                    result <= t_red[W-1:0];
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mont_exp_engine.sv
// Montgomery-domain modular exponentiation M^e mod n, left-to-right
// square-and-multiply over a shared bit-serial Montgomery multiplier.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle start pulse, honoured only when idle
//   e, e_idx          exponent and index of its top bit to process
//   n, mp_count       odd modulus and Montgomery iteration count k
//   host_wr_*         host preload port for X_bar / M_bar (idle only)
//   stop              done flag, held until the next accepted start
//   ans               zero-extended result
module mont_exp_engine
    import mont_exp_engine_pkg::*;
#(
    parameter int BIT_LEN = BIT_LEN_DEFAULT,
    parameter int ABITS   = ABITS_DEFAULT,
    parameter int DBITS   = DBITS_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [BIT_LEN-1:0] e,
    input  logic [9:0]         e_idx,
    input  logic [BIT_LEN-1:0] n,
    input  logic [9:0]         mp_count,
    input  logic [ABITS-1:0]   host_wr_addr,
    input  logic [DBITS-1:0]   host_wr_data,
    input  logic               host_wr_en,
    output logic               stop,
    output logic [BIT_LEN:0]   ans
);

    exp_state_e         state, state_nx;
    logic [BIT_LEN-1:0] e_reg;
    logic [BIT_LEN-1:0] n_reg;
    logic [BIT_LEN-1:0] x;
    logic [BIT_LEN-1:0] m;
    logic [9:0]         idx;
    logic [9:0]         k_reg;
    logic               mm_issued;
    logic               mm_start;
    logic               mm_done;
    logic [BIT_LEN-1:0] mm_a;
    logic [BIT_LEN-1:0] mm_b;
    logic [BIT_LEN-1:0] mm_result;
    logic [ABITS-1:0]   rd_addr;
    logic [DBITS-1:0]   rd_data;
    logic               eng_wr_en;
    logic [BIT_LEN-1:0] e_shift;
    logic               cur_bit;
    logic               last_bit;

    assign e_shift  = e_reg >> idx;
    assign cur_bit  = e_shift[0];
    assign last_bit = (idx == 10'd0);

    bram #(
        .ABITS (ABITS),
        .DBITS (DBITS)
    ) u_bram (
        .clk       (clk),
        .wr_a_en   (eng_wr_en),
        .wr_a_addr (ABITS'(ADDR_X_LO)),
        .wr_a_data (DBITS'(x)),
        .wr_b_en   (host_wr_en),
        .wr_b_addr (host_wr_addr),
        .wr_b_data (host_wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    mont_mul #(
        .W (BIT_LEN)
    ) u_mont_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mm_start),
        .a      (mm_a),
        .b      (mm_b),
        .n      (n_reg),
        .k      (k_reg),
        .done   (mm_done),
        .result (mm_result)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and control. The read address sits on X_lo while idle so
    // that X_bar is already on rd_data in RD_X. Each multiplier state fires
    // its request once, on the first cycle where nothing is outstanding.
    always_comb begin
        state_nx  = state;
        mm_start  = 1'b0;
        mm_a      = x;
        mm_b      = x;
        rd_addr   = ABITS'(ADDR_X_LO);
        eng_wr_en = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_RD_X;
                end
            end
            ST_RD_X: begin
                rd_addr  = ABITS'(ADDR_M_LO);
                state_nx = ST_RD_M;
            end
            ST_RD_M: state_nx = ST_SQR;
            ST_SQR: begin
                mm_start = !mm_issued;
                if (mm_done) begin
                    if (cur_bit) begin
                        state_nx = ST_MUL;
                    end else if (last_bit) begin
                        state_nx = ST_CONV;
                    end else begin
                        state_nx = ST_SQR;
                    end
                end
            end
            ST_MUL: begin
                mm_a     = m;
                mm_start = !mm_issued;
                if (mm_done) begin
                    state_nx = last_bit ? ST_CONV : ST_SQR;
                end
            end
            ST_CONV: begin
                mm_b     = BIT_LEN'(1);
                mm_start = !mm_issued;
                if (mm_done) begin
                    state_nx = ST_WB;
                end
            end
            ST_WB: begin
                eng_wr_en = 1'b1;
                state_nx  = ST_DONE;
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Datapath registers. The bit index only moves on once the current
    // bit's square (and multiply, if the bit is set) has completed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_reg     <= '0;
            n_reg     <= '0;
            k_reg     <= '0;
            idx       <= '0;
            x         <= '0;
            m         <= '0;
            mm_issued <= 1'b0;
            stop      <= 1'b0;
            ans       <= '0;
        end else begin
            if (mm_start) begin
                mm_issued <= 1'b1;
            end else if (mm_done) begin
                mm_issued <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        e_reg <= e;
                        n_reg <= n;
                        k_reg <= mp_count;
                        idx   <= (e_idx >= 10'(BIT_LEN)) ? 10'(BIT_LEN - 1) : e_idx;
                        stop  <= 1'b0;
                    end
                end
                ST_RD_X: x <= rd_data[BIT_LEN-1:0];
                ST_RD_M: m <= rd_data[BIT_LEN-1:0];
                ST_SQR: begin
                    if (mm_done) begin
                        x <= mm_result;
                        if (!cur_bit && !last_bit) begin
                            idx <= idx - 10'd1;
                        end
                    end
                end
                ST_MUL: begin
                    if (mm_done) begin
                        x <= mm_result;
                        if (!last_bit) begin
                            idx <= idx - 10'd1;
                        end
                    end
                end
                ST_CONV: begin
                    if (mm_done) begin
                        x <= mm_result;
                    end
                end
                ST_DONE: begin
                    stop <= 1'b1;
                    ans  <= {1'b0, x};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mont_exp_engine.sv
// Self-checking bench for mont_exp_engine: directed scenarios on n = 589
// plus random 64-bit odd moduli checked against a plain modular-arithmetic
// reference (right-to-left exponentiation, no Montgomery arithmetic).
module tb_mont_exp_engine;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [511:0] e;
    logic [9:0]   e_idx;
    logic [511:0] n;
    logic [9:0]   mp_count;
    logic [7:0]   host_wr_addr;
    logic [511:0] host_wr_data;
    logic         host_wr_en;
    logic         stop;
    logic [512:0] ans;

    int nChecks;
    int nFails;
    int stopRises;

    mont_exp_engine u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .e            (e),
        .e_idx        (e_idx),
        .n            (n),
        .mp_count     (mp_count),
        .host_wr_addr (host_wr_addr),
        .host_wr_data (host_wr_data),
        .host_wr_en   (host_wr_en),
        .stop         (stop),
        .ans          (ans)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every rising edge of stop to catch duplicate completions
    initial stopRises = 0;
    always @(posedge stop) stopRises = stopRises + 1;

    // Reference: M^(e[idx:0]) mod nn, right-to-left binary method
    function automatic logic [63:0] refPow(input logic [63:0] mVal, input logic [511:0] ex,
                                           input int idx, input logic [63:0] nn);
        logic [127:0] r;
        logic [127:0] b;
        logic [127:0] nw;
        logic [511:0] sh;
        int           top;
        nw  = {64'b0, nn};
        r   = 128'd1 % nw;
        b   = {64'b0, mVal} % nw;
        top = (idx > 511) ? 511 : idx;
        for (int i = 0; i <= top; i++) begin
            sh = ex >> i;
            if (sh[0]) r = (r * b) % nw;
            b = (b * b) % nw;
        end
        return r[63:0];
    endfunction

    // Montgomery form v * 2^k mod nn
    function automatic logic [63:0] toMont(input logic [63:0] v, input int k, input logic [63:0] nn);
        logic [127:0] t;
        t = ({64'b0, v} << k) % {64'b0, nn};
        return t[63:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [512:0] observed, input logic [512:0] expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic hostWrite(input logic [7:0] addr, input logic [63:0] data);
        @(negedge clk);
        host_wr_addr = addr;
        host_wr_data = {448'b0, data};
        host_wr_en   = 1'b1;
        @(negedge clk);
        host_wr_en   = 1'b0;
    endtask

    // Preload X_bar / M_bar (high words zero), then pulse start
    task automatic applyStimulus(input logic [63:0] xBar, input logic [63:0] mBar, input logic [511:0] eVal,
                                 input logic [9:0] idxVal, input logic [63:0] nVal, input logic [9:0] kVal);
        hostWrite(8'd0, xBar);
        hostWrite(8'd1, 64'd0);
        hostWrite(8'd2, mBar);
        hostWrite(8'd3, 64'd0);
        @(negedge clk);
        e        = eVal;
        e_idx    = idxVal;
        n        = {448'b0, nVal};
        mp_count = kVal;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic waitStop(input string tag, input int budget);
        for (int c = 0; c < budget; c++) begin
            if (stop) break;
            @(negedge clk);
        end
        checkOutput(tag, 513'(stop), 513'd1);
    endtask

    task automatic runRandom(input int trial);
        logic [63:0]  nn;
        logic [63:0]  mm;
        logic [511:0] ex;
        int           idx;
        nn      = {$urandom(), $urandom()};
        nn[63]  = 1'b1;
        nn[0]   = 1'b1;
        mm      = {$urandom(), $urandom()} % nn;
        ex      = {448'b0, $urandom(), $urandom()};
        idx     = $urandom_range(0, 63);
        applyStimulus(toMont(64'd1, 64, nn), toMont(mm, 64, nn), ex, 10'(idx), nn, 10'd64);
        waitStop($sformatf("rand%0d_stop", trial), 20000);
        checkOutput($sformatf("rand%0d_ans", trial), ans, 513'(refPow(mm, ex, idx, nn)));
    endtask

    initial begin
        logic [511:0] eBig;
        int           rises0;
        nChecks      = 0;
        nFails       = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        e            = '0;
        e_idx        = '0;
        n            = '0;
        mp_count     = '0;
        host_wr_addr = '0;
        host_wr_data = '0;
        host_wr_en   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset_stop", 513'(stop), 513'd0);
        checkOutput("reset_ans", ans, 513'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 199^300 mod 589
        applyStimulus(64'd435, 64'd571, 512'd300, 10'd8, 64'd589, 10'd10);
        checkOutput("s1_stop_low", 513'(stop), 513'd0);
        waitStop("s1_stop", 2000);
        checkOutput("s1_ans", ans, 513'd311);
        checkOutput("s1_ans_model", ans, 513'(refPow(64'd199, 512'd300, 8, 64'd589)));
        checkOutput("s1_mem0", 513'(u_dut.u_bram.mem[0]), 513'd311);

        // 2^10 mod 589
        applyStimulus(64'd435, 64'd281, 512'd10, 10'd3, 64'd589, 10'd10);
        waitStop("s2_stop", 2000);
        checkOutput("s2_ans", ans, 513'd435);

        // e = 1 and e = 0 with a single processed bit
        applyStimulus(64'd435, 64'd571, 512'd1, 10'd0, 64'd589, 10'd10);
        waitStop("e1_stop", 2000);
        checkOutput("e1_ans", ans, 513'd199);
        applyStimulus(64'd435, 64'd571, 512'd0, 10'd0, 64'd589, 10'd10);
        waitStop("e0_stop", 2000);
        checkOutput("e0_ans", ans, 513'd1);

        // Restore a nonzero ans, then abort mid-run with reset
        applyStimulus(64'd435, 64'd571, 512'd300, 10'd8, 64'd589, 10'd10);
        waitStop("pre_rst_stop", 2000);
        applyStimulus(64'd435, 64'd571, 512'd300, 10'd8, 64'd589, 10'd10);
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_stop", 513'(stop), 513'd0);
        checkOutput("abort_ans", ans, 513'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(64'd435, 64'd571, 512'd300, 10'd8, 64'd589, 10'd10);
        waitStop("restart_stop", 2000);
        checkOutput("restart_ans", ans, 513'd311);

        // Extra start while busy must be ignored
        rises0 = stopRises;
        applyStimulus(64'd435, 64'd571, 512'd300, 10'd8, 64'd589, 10'd10);
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitStop("busy_stop", 2000);
        checkOutput("busy_ans", ans, 513'd311);
        repeat (250) @(negedge clk);
        checkOutput("busy_rises", 513'(stopRises - rises0), 513'd1);
        checkOutput("busy_hold_ans", ans, 513'd311);
        checkOutput("busy_hold_stop", 513'(stop), 513'd1);

        // mp_count = 0 makes every MonPro return 0
        applyStimulus(64'd435, 64'd571, 512'd300, 10'd8, 64'd589, 10'd0);
        waitStop("k0_stop", 2000);
        checkOutput("k0_ans", ans, 513'd0);

        // e_idx beyond the exponent width is clamped to the top bit
        eBig      = 512'd300;
        eBig[511] = 1'b1;
        applyStimulus(64'd435, 64'd571, eBig, 10'd700, 64'd589, 10'd10);
        waitStop("clamp_stop", 20000);
        checkOutput("clamp_ans", ans, 513'(refPow(64'd199, eBig, 700, 64'd589)));

        // Random 64-bit odd moduli with host-loaded operands
        for (int t = 0; t < 3; t++) begin
            runRandom(t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
